aes_word_loader: RTL and testbench
==================================

// Module: aes_word_loader
// PURPOSE
//  Upstream feeder for the AES top level (controller + core). Accepts key and plaintext as a
//  stream of WORD_W-bit words over a valid/ready handshake and assembles them into 128-bit
//  registers. Drives a one-cycle start pulse to the AES top, then holds both operands stable
//  until the AES top reports done. Provides the plain_text/cipher_key/start inputs of that block.
// PARAMETERS
//  WORD_W   32   input word width; must be 8, 16, 32 or 64. Derived: NW = 128/WORD_W words/operand
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rstn        in   1       synchronous reset, active low
//  in_valid    in   1       word present on in_data
//  in_ready    out  1       loader can accept a word this cycle
//  in_data     in   WORD_W  word; first word of a sequence = bits [127:128-WORD_W]
//  in_is_key   in   1       1 = key word, 0 = plaintext word; qualified by in_valid
//  aes_done    in   1       done from AES top (level)
//  start       out  1       one-cycle start pulse to AES top
//  plain_text  out  128     assembled plaintext, stable from start until exit of WAIT
//  cipher_key  out  128     assembled key, stable while busy
//  key_valid   out  1       a complete key has been loaded since reset
//  busy        out  1       high in START and WAIT
//  err         out  1       one-cycle pulse on protocol error
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active low (rstn). Reset on any edge, incl. mid-
//    operation: state=IDLE, count=0, staging=0, all outputs 0 (in_ready=0 only during rstn low).
//  - Transfer = in_valid & in_ready. in_ready = 1 in IDLE/LOAD, 0 in START/WAIT.
//  - States: IDLE (no partial sequence), LOAD (1..NW-1 words staged), START, WAIT.
//  - Word transfer: staging <= {staging[127-WORD_W:0], in_data}; count increments; sequence
//    type latched from in_is_key of its first word.
//  - Type mismatch mid-sequence (in_is_key != latched type): err pulses next cycle; partial
//    sequence discarded; offending word accepted as word 0 of a new sequence of its own type.
//  - Sequence complete (NW-th word; count wraps to 0):
//     key: cipher_key <= assembled value, key_valid <= 1, state -> IDLE. Never starts AES.
//     plaintext & key_valid: plain_text <= assembled value, state -> START.
//     plaintext & !key_valid: err pulse, plain_text unchanged, state -> IDLE.
//  - NW==1: every word completes a sequence; LOAD is never entered.
//  - START: start=1 for exactly this one cycle (registered); next state WAIT. Latency: last word
//    accepted at edge T -> start high in cycle T+1.
//  - WAIT: done_q is aes_done registered. Exit to IDLE on first cycle with aes_done & !done_q
//    (rising edge); a done level left over from a previous operation never ends WAIT.
//    busy drops and in_ready rises in the cycle after the edge.
//  - plain_text/cipher_key change only on sequence completion, never during START/WAIT.
//  - in_valid with in_ready=0: not accepted, no side effect; source holds word (no drop).
// STRUCTURE
//  - Shared package aes_loader_pkg: state localparams (IDLE=0, LOAD=1, START=2, WAIT=3),
//    NW derivation, count width $clog2(NW) (min 1).
//  - Sub-module aes_word_assembler: staging shift register + word counter + type latch;
//    outputs word_done, seq_is_key, mismatch. Top holds FSM, output registers, done_q.
// TESTING
//  1. FIPS-197: key 000102..0f, pt 00112233..ff, WORD_W=32, 8 back-to-back words -> start one
//     cycle after 8th word; cipher_key/plain_text exact; AES top out 69c4e0d86a7b0430d8cdb78070b4c55a.
//  2. Plaintext with no key after reset -> err pulse, no start, state IDLE, plain_text==0.
//  3. 2 key words, then in_is_key=0 word -> err pulse; later 3 pt words complete plaintext
//     (4 total incl. offending word) -> start asserted.
//  4. Stale done: hold aes_done=1 across start -> loader stays busy until done 0->1;
//     in_ready=0, in_valid words not consumed throughout WAIT.
//  5. rstn low 1 cycle during WAIT and during LOAD -> all outputs 0, key_valid=0, count=0 next cycle.
//  6. WORD_W=8 and 64: random key/pt, random in_valid gaps -> assembled values match; no start
//     before NW-th transfer.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared definitions for the AES word loader: FSM states and operand/word geometry helpers.
package aes_loader_pkg;

    localparam int unsigned BlockW = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StStart = 2'd2,
        StWait  = 2'd3
    } state_e;

    // Words per 128-bit operand.
    function automatic int unsigned num_words(input int unsigned word_w);
        return BlockW / word_w;
    endfunction

    // Word counter width; a single-word operand still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/aes_word_assembler.sv
// Staging shift register, word counter and sequence-type latch for one operand stream.
module aes_word_assembler
    import aes_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              xfer_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              is_key_i,
    output logic [127:0]      assembled_o,
    output logic              word_done_o,
    output logic              seq_is_key_o,
    output logic              mismatch_o
);

    localparam int unsigned NW   = num_words(WORD_W);
    localparam int unsigned CntW = cnt_width(NW);
    localparam logic [CntW-1:0] LastCnt = CntW'(NW - 1);

    logic [127:0]    staging_q, staging_d;
    logic [CntW-1:0] count_q, count_d;
    logic            type_q, type_d;

    // Value the staging register would hold after accepting the current word.
    assign assembled_o = {staging_q[127-WORD_W:0], data_i};

    // Classify the incoming word and compute next staging/counter/type.
    always_comb begin
        mismatch_o   = xfer_i && (count_q != '0) && (is_key_i != type_q);
        seq_is_key_o = (count_q == '0) ? is_key_i : type_q;
        word_done_o  = xfer_i && !mismatch_o && (count_q == LastCnt);
        staging_d    = staging_q;
        count_d      = count_q;
        type_d       = type_q;
        if (mismatch_o) begin
            // Drop the partial sequence; the offending word starts a fresh one.
            staging_d = {{(128-WORD_W){1'b0}}, data_i};
            count_d   = CntW'(1);
            type_d    = is_key_i;
        end else if (xfer_i) begin
            staging_d = assembled_o;
            count_d   = word_done_o ? '0 : count_q + 1'b1;
            if (count_q == '0) begin
                type_d = is_key_i;
            end
        end
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            staging_q <= '0;
            count_q   <= '0;
            type_q    <= 1'b0;
        end else begin
            staging_q <= staging_d;
            count_q   <= count_d;
            type_q    <= type_d;
        end
    end

endmodule

// File: rtl/aes_word_loader.sv
// Assembles key/plaintext words into 128-bit operands and launches the AES top with a start pulse.
module aes_word_loader
    import aes_loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_is_key,
    input  logic              aes_done,
    output logic              start,
    output logic [127:0]      plain_text,
    output logic [127:0]      cipher_key,
    output logic              key_valid,
    output logic              busy,
    output logic              err
);

    state_e       state_q;
    logic         done_q;
    logic         start_q;
    logic         busy_q;
    logic         err_q;
    logic         key_valid_q;
    logic [127:0] pt_q;
    logic [127:0] key_q;

    logic         xfer;
    logic [127:0] assembled;
    logic         word_done;
    logic         seq_is_key;
    logic         mismatch;

    // Ready only while no operation is in flight; forced low while reset is asserted.
    assign in_ready = rstn && ((state_q == StIdle) || (state_q == StLoad));
    assign xfer     = in_valid && in_ready;

    aes_word_assembler #(
        .WORD_W (WORD_W)
    ) u_assembler (
        .clk          (clk),
        .rstn         (rstn),
        .xfer_i       (xfer),
        .data_i       (in_data),
        .is_key_i     (in_is_key),
        .assembled_o  (assembled),
        .word_done_o  (word_done),
        .seq_is_key_o (seq_is_key),
        .mismatch_o   (mismatch)
    );

    // Control FSM with registered start/busy/err and operand registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
            pt_q        <= '0;
            key_q       <= '0;
        end else begin
            done_q  <= aes_done;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle, StLoad: begin
                    if (mismatch) begin
                        err_q   <= 1'b1;
                        state_q <= StLoad;
                    end else if (word_done) begin
                        if (seq_is_key) begin
                            key_q       <= assembled;
                            key_valid_q <= 1'b1;
                            state_q     <= StIdle;
                        end else if (key_valid_q) begin
                            pt_q    <= assembled;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= StStart;
                        end else begin
                            // Plaintext without a key: reject and keep the old plaintext.
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else if (xfer) begin
                        state_q <= StLoad;
                    end
                end
                StStart: begin
                    state_q <= StWait;
                end
                StWait: begin
                    // Only a fresh rising edge of done ends the operation.
                    if (aes_done && !done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign start      = start_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign key_valid  = key_valid_q;
    assign plain_text = pt_q;
    assign cipher_key = key_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed self-checking bench for aes_word_loader at WORD_W = 32, 8 and 64.
module tb_aes_word_loader;

    logic clk;
    logic rstn;

    // 32-bit instance
    logic         vld32, rdy32, isk32, done32;
    logic [31:0]  dat32;
    logic         start32, kv32, busy32, err32;
    logic [127:0] pt32, ck32;

    // 8-bit instance
    logic         vld8, rdy8, isk8;
    logic [7:0]   dat8;
    logic         start8, kv8, busy8, err8;
    logic [127:0] pt8, ck8;

    // 64-bit instance
    logic         vld64, rdy64, isk64;
    logic [63:0]  dat64;
    logic         start64, kv64, busy64, err64;
    logic [127:0] pt64, ck64;

    int passed = 0;
    int total  = 0;

    aes_word_loader #(.WORD_W(32)) u_dut32 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (vld32),
        .in_ready   (rdy32),
        .in_data    (dat32),
        .in_is_key  (isk32),
        .aes_done   (done32),
        .start      (start32),
        .plain_text (pt32),
        .cipher_key (ck32),
        .key_valid  (kv32),
        .busy       (busy32),
        .err        (err32)
    );

    aes_word_loader #(.WORD_W(8)) u_dut8 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (vld8),
        .in_ready   (rdy8),
        .in_data    (dat8),
        .in_is_key  (isk8),
        .aes_done   (1'b0),
        .start      (start8),
        .plain_text (pt8),
        .cipher_key (ck8),
        .key_valid  (kv8),
        .busy       (busy8),
        .err        (err8)
    );

    aes_word_loader #(.WORD_W(64)) u_dut64 (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (vld64),
        .in_ready   (rdy64),
        .in_data    (dat64),
        .in_is_key  (isk64),
        .aes_done   (1'b0),
        .start      (start64),
        .plain_text (pt64),
        .cipher_key (ck64),
        .key_valid  (kv64),
        .busy       (busy64),
        .err        (err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] w, input logic k);
        int n = 0;
        vld32 = 1'b1; dat32 = w; isk32 = k;
        while (!rdy32 && n < 40) begin tick(); n++; end
        chk("send32_ready", rdy32, 1'b1);
        tick();
        vld32 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] w, input logic k);
        int n = 0;
        vld8 = 1'b1; dat8 = w; isk8 = k;
        while (!rdy8 && n < 40) begin tick(); n++; end
        chk("send8_ready", rdy8, 1'b1);
        tick();
        vld8 = 1'b0;
    endtask

    task automatic send64(input logic [63:0] w, input logic k);
        int n = 0;
        vld64 = 1'b1; dat64 = w; isk64 = k;
        while (!rdy64 && n < 40) begin tick(); n++; end
        chk("send64_ready", rdy64, 1'b1);
        tick();
        vld64 = 1'b0;
    endtask

    initial begin
        logic [127:0] k8, p8, k64, p64, fkey, fpt;
        fkey = 128'h000102030405060708090a0b0c0d0e0f;
        fpt  = 128'h00112233445566778899aabbccddeeff;
        k8   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        p8   = 128'h3243f6a8885a308d313198a2e0370734;
        k64  = 128'h603deb1015ca71be2b73aef0857d7781;
        p64  = 128'h6bc1bee22e409f96e93d7e117393172a;

        rstn = 1'b0; done32 = 1'b0;
        vld32 = 1'b0; dat32 = '0; isk32 = 1'b0;
        vld8 = 1'b0; dat8 = '0; isk8 = 1'b0;
        vld64 = 1'b0; dat64 = '0; isk64 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ready_low", rdy32, 1'b0);
        chk("rst_start", start32, 1'b0);
        chk("rst_busy", busy32, 1'b0);
        chk("rst_kv", kv32, 1'b0);
        chk("rst_pt", pt32, 128'h0);
        chk("rst_ck", ck32, 128'h0);
        rstn = 1'b1;
        tick();
        chk("idle_ready", rdy32, 1'b1);

        // FIPS-197 key then plaintext, back to back
        send32(32'h00010203, 1'b1);
        send32(32'h04050607, 1'b1);
        send32(32'h08090a0b, 1'b1);
        send32(32'h0c0d0e0f, 1'b1);
        chk("fips_key", ck32, fkey);
        chk("fips_kv", kv32, 1'b1);
        chk("key_no_start", busy32, 1'b0);
        send32(32'h00112233, 1'b0);
        send32(32'h44556677, 1'b0);
        send32(32'h8899aabb, 1'b0);
        chk("pt_no_early_start", busy32, 1'b0);
        send32(32'hccddeeff, 1'b0);
        chk("fips_start", start32, 1'b1);
        chk("fips_pt", pt32, fpt);
        chk("fips_busy", busy32, 1'b1);
        tick();
        chk("start_one_cycle", start32, 1'b0);
        chk("wait_ready_low", rdy32, 1'b0);
        done32 = 1'b1;
        tick();
        chk("done_exit_busy", busy32, 1'b0);
        chk("done_exit_ready", rdy32, 1'b1);
        done32 = 1'b0;
        tick();

        // Type mismatch mid-sequence
        send32(32'haaaa0001, 1'b1);
        send32(32'haaaa0002, 1'b1);
        send32(32'h11111111, 1'b0);
        chk("mismatch_err", err32, 1'b1);
        chk("mismatch_key_kept", ck32, fkey);
        send32(32'h22222222, 1'b0);
        chk("err_one_cycle", err32, 1'b0);
        send32(32'h33333333, 1'b0);
        send32(32'h44444444, 1'b0);
        chk("mismatch_start", start32, 1'b1);
        chk("mismatch_pt", pt32, 128'h11111111222222223333333344444444);
        tick();
        done32 = 1'b1;
        tick();
        done32 = 1'b0;
        chk("mismatch_exit", busy32, 1'b0);

        // Stale done level held across start
        done32 = 1'b1;
        send32(32'h0badf00d, 1'b0);
        send32(32'h0badf00d, 1'b0);
        send32(32'h0badf00d, 1'b0);
        send32(32'h0badf00d, 1'b0);
        chk("stale_start", start32, 1'b1);
        vld32 = 1'b1; dat32 = 32'hc0de0000; isk32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_busy", busy32, 1'b1);
            chk("stale_ready", rdy32, 1'b0);
        end
        done32 = 1'b0;
        tick();
        chk("done_low_busy", busy32, 1'b1);
        done32 = 1'b1;
        tick();
        chk("edge_exit_busy", busy32, 1'b0);
        send32(32'hc0de0000, 1'b1);
        send32(32'hc0de0001, 1'b1);
        send32(32'hc0de0002, 1'b1);
        send32(32'hc0de0003, 1'b1);
        chk("held_word_once", ck32, 128'hc0de0000c0de0001c0de0002c0de0003);
        chk("pt_stable", pt32, 128'h0badf00d0badf00d0badf00d0badf00d);
        done32 = 1'b0;

        // Reset during WAIT
        for (int i = 0; i < 4; i++) send32(32'h55555555, 1'b0);
        tick();
        chk("pre_rst_busy", busy32, 1'b1);
        rstn = 1'b0;
        tick();
        chk("rstw_ready", rdy32, 1'b0);
        chk("rstw_busy", busy32, 1'b0);
        chk("rstw_kv", kv32, 1'b0);
        chk("rstw_pt", pt32, 128'h0);
        chk("rstw_ck", ck32, 128'h0);
        rstn = 1'b1;
        tick();
        chk("rstw_ready_back", rdy32, 1'b1);

        // Plaintext with no key
        for (int i = 0; i < 4; i++) send32(32'h77777777, 1'b0);
        chk("nokey_err", err32, 1'b1);
        chk("nokey_start", start32, 1'b0);
        chk("nokey_busy", busy32, 1'b0);
        chk("nokey_pt", pt32, 128'h0);
        tick();
        chk("nokey_idle", rdy32, 1'b1);
        chk("nokey_err_drop", err32, 1'b0);

        // Reset during LOAD clears the word count
        send32(32'hdead0001, 1'b1);
        send32(32'hdead0002, 1'b1);
        rstn = 1'b0;
        tick();
        chk("rstl_ready", rdy32, 1'b0);
        rstn = 1'b1;
        tick();
        send32(32'hbeef0001, 1'b1);
        send32(32'hbeef0002, 1'b1);
        chk("rstl_count_cleared", kv32, 1'b0);
        send32(32'hbeef0003, 1'b1);
        send32(32'hbeef0004, 1'b1);
        chk("rstl_key", ck32, 128'hbeef0001beef0002beef0003beef0004);

        // WORD_W = 8 with random gaps
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send8(k8[127-8*i -: 8], 1'b1);
        end
        chk("w8_kv", kv8, 1'b1);
        chk("w8_key", ck8, k8);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == 15) chk("w8_no_early", busy8, 1'b0);
            send8(p8[127-8*i -: 8], 1'b0);
        end
        chk("w8_start", start8, 1'b1);
        chk("w8_pt", pt8, p8);

        // WORD_W = 64 with random gaps
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send64(k64[127-64*i -: 64], 1'b1);
        end
        chk("w64_key", ck64, k64);
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (i == 1) chk("w64_no_early", busy64, 1'b0);
            send64(p64[127-64*i -: 64], 1'b0);
        end
        chk("w64_start", start64, 1'b1);
        chk("w64_pt", pt64, p64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
